// File: rtl/survivor_mem_if.sv
// Survivor memory bus: ACS write channel plus traceback read port.
//   surv_valid  : ACS presents one symbol's decisions this cycle
//   surv_bits   : one decision bit per trellis state
//   surv_best   : lowest-metric state for this symbol
//   tb_time     : traceback read slot
//   tb_state    : traceback read state
//   tb_surv_bit : registered read data (1-cycle latency)
// master = ACS/traceback side, slave = survivor_mem.
interface survivor_mem_if #(
    parameter int unsigned K  = 7,
    parameter int unsigned M  = K - 1,
    parameter int unsigned D  = 40,
    localparam int unsigned AW = (D > 1) ? $clog2(D) : 1,
    localparam int unsigned NS = 1 << M
);
    logic          surv_valid;
    logic [NS-1:0] surv_bits;
    logic [M-1:0]  surv_best;
    logic [AW-1:0] tb_time;
    logic [M-1:0]  tb_state;
    logic          tb_surv_bit;

    modport master (
        output surv_valid, surv_bits, surv_best, tb_time, tb_state,
        input  tb_surv_bit
    );

    modport slave (
        input  surv_valid, surv_bits, surv_best, tb_time, tb_state,
        output tb_surv_bit
    );
endinterface

// File: rtl/survivor_mem.sv
// Viterbi survivor memory: circular buffer of D rows, each holding the 2^M
// decision bits of one symbol, with a fill-tracking FSM and a registered
// single-bit traceback read port.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   flush       : synchronous clear of write pointer, s_end and fill state
//   bus         : survivor_mem_if.slave (write channel + traceback read)
//   wr_ptr      : next slot to write
//   s_end       : surv_best of the last written symbol
//   full        : D symbols held since the last reset or flush
//   fill_level  : symbols held, saturating at D
// Build option: define SURV_RDW_FWD_EN to forward the incoming decision bits
// when the traceback reads the row being written in the same cycle; without
// it such a read returns the row's previous contents.
module survivor_mem #(
    parameter int unsigned K  = 7,
    parameter int unsigned M  = K - 1,
    parameter int unsigned D  = 40,
    localparam int unsigned AW = (D > 1) ? $clog2(D) : 1,
    localparam int unsigned NS = 1 << M
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    survivor_mem_if.slave bus,
    output logic [AW-1:0] wr_ptr,
    output logic [M-1:0]  s_end,
    output logic          full,
    output logic [AW:0]   fill_level
);

    localparam logic [AW-1:0] LastPtr = AW'(D - 1);
    localparam logic [AW:0]   DFill   = (AW + 1)'(D);
    localparam logic [AW:0]   OneFill = (AW + 1)'(1);

    typedef enum logic [1:0] {StEmpty, StFilling, StFull} fill_state_e;

    fill_state_e   state_q;
    logic [NS-1:0] mem_q [D];
    logic          wr_en;
    logic          rd_bit_d;

    // A flush drops any symbol presented alongside it.
    assign wr_en = bus.surv_valid & ~flush;

    // Row storage is not reset; rst_n only blocks a write in flight.
    always_ff @(posedge clk) begin
        if (wr_en && rst_n) begin
            mem_q[wr_ptr] <= bus.surv_bits;
        end
    end

    always_comb begin
        rd_bit_d = 1'b0;
        if (32'(bus.tb_time) < D) begin
`ifdef SURV_RDW_FWD_EN
            if (wr_en && (bus.tb_time == wr_ptr)) begin
                rd_bit_d = bus.surv_bits[bus.tb_state];
            end else begin
                rd_bit_d = mem_q[bus.tb_time][bus.tb_state];
            end
`else
            rd_bit_d = mem_q[bus.tb_time][bus.tb_state];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.tb_surv_bit <= 1'b0;
        end else begin
            bus.tb_surv_bit <= rd_bit_d;
        end
    end

    // Fill FSM; all status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            wr_ptr     <= '0;
            s_end      <= '0;
            full       <= 1'b0;
            fill_level <= '0;
        end else if (flush) begin
            state_q    <= StEmpty;
            wr_ptr     <= '0;
            s_end      <= '0;
            full       <= 1'b0;
            fill_level <= '0;
        end else if (bus.surv_valid) begin
            wr_ptr <= (wr_ptr == LastPtr) ? '0 : wr_ptr + AW'(1);
            s_end  <= bus.surv_best;
            unique case (state_q)
                StEmpty: begin
                    fill_level <= OneFill;
                    if (DFill == OneFill) begin
                        state_q <= StFull;
                        full    <= 1'b1;
                    end else begin
                        state_q <= StFilling;
                    end
                end
                StFilling: begin
                    fill_level <= fill_level + OneFill;
                    if (fill_level + OneFill == DFill) begin
                        state_q <= StFull;
                        full    <= 1'b1;
                    end
                end
                StFull: begin
                    // Oldest row is overwritten; level stays saturated.
                end
                default: begin
                    state_q <= StEmpty;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_survivor_mem.sv
module tb_survivor_mem;

    localparam int unsigned K  = 7;
    localparam int unsigned M  = 6;
    localparam int unsigned D  = 40;
    localparam int unsigned AW = 6;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [AW-1:0] wr_ptr;
    logic [M-1:0]  s_end;
    logic          full;
    logic [AW:0]   fill_level;

    survivor_mem_if #(.K(K), .M(M), .D(D)) bus ();

    survivor_mem #(.K(K), .M(M), .D(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus),
        .wr_ptr     (wr_ptr),
        .s_end      (s_end),
        .full       (full),
        .fill_level (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: rows as plain arrays, position derived from write count.
    logic [63:0] m_row [D];
    bit          m_known [D];
    int          m_count;
    logic [M-1:0] m_send;
    logic        m_rd;
    bit          m_rd_known;

    typedef struct {
        logic        valid;
        logic        flush;
        logic [63:0] bits;
        logic [5:0]  best;
        logic [5:0]  e_ptr;
        logic [5:0]  e_send;
        logic [6:0]  e_fill;
        logic        e_full;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count    = 0;
        m_send     = '0;
        m_rd       = 1'b0;
        m_rd_known = 1'b1;
    endtask

    task automatic drive(input bit v, input bit f, input logic [63:0] b, input logic [5:0] best);
        bus.surv_valid = v;
        flush          = f;
        bus.surv_bits  = b;
        bus.surv_best  = best;
    endtask

    task automatic set_read(input int t, input int s);
        bus.tb_time  = AW'(t);
        bus.tb_state = M'(s);
    endtask

    // One clock: predict from current inputs, clock, then compare everything.
    task automatic step();
        int t;
        int ws;
        bit writing;
        t       = int'(bus.tb_time);
        ws      = m_count % D;
        writing = bus.surv_valid && !flush;
        if (t >= D) begin
            m_rd       = 1'b0;
            m_rd_known = 1'b1;
        end else begin
            m_rd       = m_row[t][bus.tb_state];
            m_rd_known = m_known[t];
`ifdef SURV_RDW_FWD_EN
            if (writing && t == ws) begin
                m_rd       = bus.surv_bits[bus.tb_state];
                m_rd_known = 1'b1;
            end
`endif
        end
        if (flush) begin
            m_count = 0;
            m_send  = '0;
        end else if (bus.surv_valid) begin
            m_row[ws]   = bus.surv_bits;
            m_known[ws] = 1'b1;
            m_count++;
            m_send      = bus.surv_best;
        end
        @(posedge clk);
        #1;
        check("wr_ptr", 64'(wr_ptr), 64'(m_count % D));
        check("s_end", 64'(s_end), 64'(m_send));
        check("fill_level", 64'(fill_level), 64'((m_count > D) ? D : m_count));
        check("full", 64'(full), 64'(m_count >= D));
        if (m_rd_known) check("tb_surv_bit", 64'(bus.tb_surv_bit), 64'(m_rd));
    endtask

    task automatic write_rand(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, 1'b0, {$urandom, $urandom}, 6'($urandom));
            step();
        end
    endtask

    initial begin
        for (int i = 0; i < D; i++) m_known[i] = 1'b0;
        model_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, '0, '0);
        set_read(63, 0);
        #12;
        check("rst wr_ptr", 64'(wr_ptr), 64'd0);
        check("rst s_end", 64'(s_end), 64'd0);
        check("rst fill", 64'(fill_level), 64'd0);
        check("rst full", 64'(full), 64'd0);
        check("rst tb_bit", 64'(bus.tb_surv_bit), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Three writes with best 5,9,12, hold, flush-over-valid, one write.
        vecs[0] = '{1'b1, 1'b0, 64'h1,  6'd5,  6'd1, 6'd5,  7'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 64'h2,  6'd9,  6'd2, 6'd9,  7'd2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 64'h4,  6'd12, 6'd3, 6'd12, 7'd3, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 64'hF,  6'd33, 6'd3, 6'd12, 7'd3, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 64'hF,  6'd7,  6'd0, 6'd0,  7'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 64'h8,  6'd1,  6'd1, 6'd1,  7'd1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].flush, vecs[i].bits, vecs[i].best);
            step();
            check($sformatf("vec%0d wr_ptr", i), 64'(wr_ptr), 64'(vecs[i].e_ptr));
            check($sformatf("vec%0d s_end", i), 64'(s_end), 64'(vecs[i].e_send));
            check($sformatf("vec%0d fill", i), 64'(fill_level), 64'(vecs[i].e_fill));
            check($sformatf("vec%0d full", i), 64'(full), 64'(vecs[i].e_full));
        end

        // Bit 17 of row 7, then neighbouring state 16.
        drive(1'b0, 1'b1, '0, '0);
        step();
        write_rand(7);
        drive(1'b1, 1'b0, 64'h1 << 17, 6'd3);
        step();
        drive(1'b0, 1'b0, '0, '0);
        set_read(7, 17);
        step();
        check("row7 st17", 64'(bus.tb_surv_bit), 64'd1);
        set_read(7, 16);
        step();
        check("row7 st16", 64'(bus.tb_surv_bit), 64'd0);

        // Same-cycle read/write of row 4: old bit 0, new bit 1.
        drive(1'b0, 1'b1, '0, '0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 64'h0, 6'd0);
            step();
        end
        drive(1'b0, 1'b1, '0, '0);
        step();
        write_rand(4);
        set_read(4, 9);
        drive(1'b1, 1'b0, 64'h1 << 9, 6'd2);
        step();
`ifdef SURV_RDW_FWD_EN
        check("rdw row4", 64'(bus.tb_surv_bit), 64'd1);
`else
        check("rdw row4", 64'(bus.tb_surv_bit), 64'd0);
`endif
        drive(1'b0, 1'b0, '0, '0);
        step();
        check("row4 after", 64'(bus.tb_surv_bit), 64'd1);

        // Flush with valid at wr_ptr=10: row 10 keeps its old contents.
        set_read(63, 0);
        drive(1'b0, 1'b1, '0, '0);
        step();
        write_rand(10);
        drive(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 6'd1);
        step();
        drive(1'b0, 1'b1, '0, '0);
        step();
        write_rand(10);
        check("pre-flush ptr", 64'(wr_ptr), 64'd10);
        drive(1'b1, 1'b1, 64'h0, 6'd4);
        step();
        check("flush ptr", 64'(wr_ptr), 64'd0);
        check("flush fill", 64'(fill_level), 64'd0);
        drive(1'b0, 1'b0, '0, '0);
        set_read(10, 3);
        step();
        check("row10 kept", 64'(bus.tb_surv_bit), 64'd1);

        // Fill to D, then wrap over row 0.
        set_read(63, 0);
        drive(1'b0, 1'b1, '0, '0);
        step();
        write_rand(39);
        check("39 full", 64'(full), 64'd0);
        write_rand(1);
        check("40 full", 64'(full), 64'd1);
        check("40 ptr", 64'(wr_ptr), 64'd0);
        check("40 fill", 64'(fill_level), 64'd40);
        drive(1'b1, 1'b0, 64'h1 << 33, 6'd8);
        step();
        check("41 fill", 64'(fill_level), 64'd40);
        check("41 ptr", 64'(wr_ptr), 64'd1);
        drive(1'b0, 1'b0, '0, '0);
        set_read(0, 33);
        step();
        check("row0 overwritten", 64'(bus.tb_surv_bit), 64'd1);

        // Asynchronous reset pulse between edges while full.
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("arst ptr", 64'(wr_ptr), 64'd0);
        check("arst s_end", 64'(s_end), 64'd0);
        check("arst fill", 64'(fill_level), 64'd0);
        check("arst full", 64'(full), 64'd0);
        check("arst tb_bit", 64'(bus.tb_surv_bit), 64'd0);
        #1;
        rst_n = 1'b1;
        set_read(63, 0);
        drive(1'b1, 1'b0, 64'h1 << 50, 6'd11);
        step();
        check("post-rst ptr", 64'(wr_ptr), 64'd1);
        drive(1'b0, 1'b0, '0, '0);
        set_read(0, 50);
        step();
        check("post-rst row0", 64'(bus.tb_surv_bit), 64'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 3,
                  {$urandom, $urandom}, 6'($urandom));
            if ($urandom_range(0, 1) == 0) set_read(m_count % D, $urandom_range(0, 63));
            else set_read($urandom_range(0, 47), $urandom_range(0, 63));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
